serial_frame_rx: RTL and testbench
==================================

Name: serial_frame_rx

Overview:
- Downstream consumer of the free-running shift-register stage: takes its serial output bit stream and recovers framed parallel words.
- Hunts for a fixed sync pattern, then deserializes a fixed number of WIDTH-bit words MSB-first.
- Presents each word to the next stage over a valid/ready handshake, with sticky overrun reporting.

Parameters:
WIDTH, 8, bits per data word.
SYNC_LEN, 8, sync pattern length in bits.
SYNC_PAT, 8'hA5, sync pattern, MSB received first.
WORDS, 4, data words per frame after sync (>=1).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous reset, active-low.
s_in  in  1  serial bit stream from the shift-register stage.
en  in  1  bit strobe; s_in sampled only on edges where en=1.
data_out  out  WIDTH  last completed word.
data_valid  out  1  data_out holds an unconsumed word.
data_ready  in  1  consumer accepts data_out on an edge where data_valid=1.
sync_lock  out  1  1 while in CAPTURE.
frame_end  out  1  one-cycle pulse when the last word of a frame completes.
overrun  out  1  sticky: a completed word was dropped.
clr_overrun  in  1  clears overrun.

Behaviour:
- Reset (rst=0 at a rising edge):
  - State=HUNT; sync window, fill counter, bit_cnt, word_cnt and word shift register all cleared.
  - Outputs data_out=0, data_valid=0, sync_lock=0, frame_end=0, overrun=0.
  - Reset takes priority over every other input, including mid-frame and mid-word.
- HUNT:
  - On each en=1 edge: window <= {window[SYNC_LEN-2:0], s_in}; fill counter saturates at SYNC_LEN.
  - Match is evaluated on the updated window and is valid only once fill >= SYNC_LEN. An all-zero SYNC_PAT therefore cannot match straight after reset or re-entry.
  - On match: go to CAPTURE; sync_lock=1 from that edge; bit_cnt=0, word_cnt=0.
  - Bits are never consumed on en=0 edges.
- CAPTURE:
  - On each en=1 edge: shift s_in into the word register MSB-first and increment bit_cnt.
  - The edge sampling bit WIDTH-1 completes the word. bit_cnt wraps to 0.
  - Load into data_out at that same edge, so data_valid=1 is visible the cycle after the final bit's edge (zero added latency).
- Completion rules at the completing edge:
  - data_valid=0: load the word, data_valid<=1.
  - data_valid=1 and data_ready=1: old word is consumed and the new word is loaded; data_valid stays 1 and no overrun.
  - data_valid=1 and data_ready=0: new word is dropped, data_out is unchanged, overrun<=1.
- Handshake without completion: data_valid=1 and data_ready=1 gives data_valid<=0 and data_out holds its value.
- Frame end:
  - Completion of word WORDS-1 (counted whether the word was loaded or dropped) pulses frame_end=1 for one cycle.
  - The same edge returns to HUNT: sync_lock<=0, window and fill cleared. The next frame needs a complete fresh sync.
- Overrun: clr_overrun=1 clears it; a set condition on the same edge wins.
- Sync bits are never output as data. The data_valid/data_ready handshake keeps operating in HUNT.

Test Plan:
- Reset mid-frame: lock on 0xA5, drive 3 data bits, rst=0 one edge -> all outputs 0, sync_lock=0; the next bits 0x3C are not captured until a new 0xA5 arrives.
- Nominal frame (WORDS=2, en=1 every cycle, data_ready=1):
  - Stream 0xA5,0x3C,0xF0 -> sync_lock=1 after the 8th bit.
  - data_valid with 0x3C after bit 16; data_valid with 0xF0 after bit 24.
  - frame_end pulses with 0xF0; sync_lock=0 afterward.
- Sync search:
  - Bits 1,1,0 then 0xA4 -> no lock.
  - Then 0xA5 -> lock exactly on its last bit.
  - A fresh reset followed by 7 bits -> no lock even if a pattern prefix matches.
- Backpressure (data_ready=0, WORDS=2):
  - 0xA5,0x3C,0xF0 -> data_out=0x3C held, overrun=1, 0xF0 dropped, frame_end still pulses.
  - Then clr_overrun=1 -> overrun=0.
- Bit strobe gaps: repeat the nominal frame with en alternating 1/0 -> identical words and flags, with timing doubled; s_in changes on en=0 cycles are ignored.
- Simultaneous events:
  - data_ready=1 on the edge 0xF0 completes while 0x3C is pending -> data_out=0xF0, data_valid=1, overrun=0.
  - clr_overrun=1 on the same edge as a dropped word -> overrun=1.

Source files
------------

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync pattern in a strobed bit stream, then
// deserializes WORDS MSB-first words and hands them out over valid/ready.
module serial_frame_rx #(
    parameter int                  WIDTH    = 8,
    parameter int                  SYNC_LEN = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_PAT = 8'hA5,
    parameter int                  WORDS    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_in,
    input  logic             en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             sync_lock,
    output logic             frame_end,
    output logic             overrun,
    input  logic             clr_overrun
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int FW = $clog2(SYNC_LEN + 1);

    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [CW-1:0] WORD_LAST = CW'(WORDS - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(SYNC_LEN);
    localparam logic [FW-1:0] FILL_PRE  = FW'(SYNC_LEN - 1);

    typedef enum logic {
        HUNT    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [SYNC_LEN-1:0] window;
    logic [SYNC_LEN-1:0] window_next;
    logic [FW-1:0]       fill;
    logic [BW-1:0]       bit_cnt;
    logic [CW-1:0]       word_cnt;
    logic [WIDTH-1:0]    shreg;
    logic [WIDTH-1:0]    word_next;
    logic                match;
    logic                word_done;
    logic                last_word;
    logic                drop;

    // The match looks at the window including this edge's bit; fill must reach
    // SYNC_LEN so stale zeros after a clear can never satisfy the pattern.
    always_comb begin
        window_next = {window[SYNC_LEN-2:0], s_in};
        word_next   = {shreg[WIDTH-2:0], s_in};
        match       = (state == HUNT) && en && (fill >= FILL_PRE)
                      && (window_next == SYNC_PAT);
        word_done   = (state == CAPTURE) && en && (bit_cnt == BIT_LAST);
        last_word   = word_done && (word_cnt == WORD_LAST);
        drop        = word_done && data_valid && !data_ready;
    end

    always_comb begin
        state_next = state;
        case (state)
            HUNT:    if (match) state_next = CAPTURE;
            CAPTURE: if (last_word) state_next = HUNT;
            default: state_next = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            window   <= '0;
            fill     <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            shreg    <= '0;
        end else if (state == HUNT) begin
            if (en) begin
                window <= window_next;
                if (fill != FILL_FULL) fill <= fill + 1'b1;
                if (match) begin
                    bit_cnt  <= '0;
                    word_cnt <= '0;
                end
            end
        end else if (en) begin
            shreg <= word_next;
            if (word_done) begin
                bit_cnt <= '0;
                if (last_word) begin
                    word_cnt <= '0;
                    window   <= '0;
                    fill     <= '0;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // A completing word is loaded unless an unconsumed word is being held;
    // with data_ready high the old word is consumed on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_end  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_end <= last_word;
            if (word_done) begin
                if (!drop) begin
                    data_out   <= word_next;
                    data_valid <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    assign sync_lock = (state == CAPTURE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx with WORDS=2, sync 0xA5, 8-bit words.
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s_in = 1'b0;
    logic       en = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready = 1'b1;
    logic       sync_lock;
    logic       frame_end;
    logic       overrun;
    logic       clr_overrun = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    serial_frame_rx #(
        .WIDTH(8), .SYNC_LEN(8), .SYNC_PAT(8'hA5), .WORDS(2)
    ) dut (
        .clk(clk), .rst(rst), .s_in(s_in), .en(en),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .sync_lock(sync_lock), .frame_end(frame_end), .overrun(overrun),
        .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends the top n bits of v MSB-first; in gap mode each bit is preceded by
    // an en=0 cycle carrying the inverted bit.
    task automatic send_bits(input logic [7:0] v, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                s_in = ~v[7-i];
                en   = 1'b0;
                tick();
            end
            s_in = v[7-i];
            en   = 1'b1;
            tick();
        end
        en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gap);
        send_bits(v, 8, gap);
    endtask

    task automatic send_bit(input logic b, input bit gap);
        send_bits({b, 7'b0}, 1, gap);
    endtask

    task automatic idle();
        en = 1'b0;
        tick();
    endtask

    initial begin
        logic [10:0] hunt_bits;

        // Reset state
        tick();
        tick();
        rst = 1'b1;
        check("rst_data_out", data_out, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_sync_lock", sync_lock, 0);
        check("rst_frame_end", frame_end, 0);
        check("rst_overrun", overrun, 0);

        // Nominal frame
        send_bits(8'hA5, 7, 0);
        check("nom_lock_pre", sync_lock, 0);
        send_bit(1'b1, 0);
        check("nom_lock", sync_lock, 1);
        send_byte(8'h3C, 0);
        check("nom_w0_valid", data_valid, 1);
        check("nom_w0_data", data_out, 8'h3C);
        check("nom_w0_fe", frame_end, 0);
        send_byte(8'hF0, 0);
        check("nom_w1_valid", data_valid, 1);
        check("nom_w1_data", data_out, 8'hF0);
        check("nom_w1_fe", frame_end, 1);
        check("nom_unlock", sync_lock, 0);
        idle();
        check("nom_fe_pulse", frame_end, 0);
        check("nom_consumed", data_valid, 0);
        check("nom_data_hold", data_out, 8'hF0);

        // Sync search: 1,1,0 then 0xA4 never locks; 0xA5 locks on its last bit
        hunt_bits = 11'b110_1010_0100;
        for (int i = 10; i >= 0; i--) begin
            send_bit(hunt_bits[i], 0);
            check("hunt_nolock", sync_lock, 0);
        end
        send_bits(8'hA5, 7, 0);
        check("hunt_a5_pre", sync_lock, 0);
        send_bit(1'b1, 0);
        check("hunt_a5_lock", sync_lock, 1);

        // Reset mid-frame
        send_bits(8'h3C, 3, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mid_rst_data_out", data_out, 0);
        check("mid_rst_valid", data_valid, 0);
        check("mid_rst_lock", sync_lock, 0);
        check("mid_rst_fe", frame_end, 0);
        check("mid_rst_overrun", overrun, 0);
        send_byte(8'h3C, 0);
        check("mid_rst_nocap_lock", sync_lock, 0);
        check("mid_rst_nocap_valid", data_valid, 0);

        // Fresh reset then 7 bits completing a prefix with a pre-reset 1
        send_bit(1'b1, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        send_bits(8'h4A, 7, 0);
        check("prefix_nolock", sync_lock, 0);

        // Backpressure
        data_ready = 1'b0;
        send_bits(8'hA5, 7, 0);
        check("bp_lock_pre", sync_lock, 0);
        send_bit(1'b1, 0);
        check("bp_lock", sync_lock, 1);
        send_byte(8'h3C, 0);
        check("bp_w0_valid", data_valid, 1);
        check("bp_w0_data", data_out, 8'h3C);
        check("bp_w0_overrun", overrun, 0);
        send_byte(8'hF0, 0);
        check("bp_held_data", data_out, 8'h3C);
        check("bp_held_valid", data_valid, 1);
        check("bp_overrun", overrun, 1);
        check("bp_fe", frame_end, 1);
        check("bp_unlock", sync_lock, 0);
        clr_overrun = 1'b1;
        idle();
        clr_overrun = 1'b0;
        check("bp_clr_overrun", overrun, 0);
        check("bp_still_valid", data_valid, 1);

        // Handshake in HUNT, then ready on the completing edge
        data_ready = 1'b1;
        idle();
        check("hs_consume", data_valid, 0);
        check("hs_data_hold", data_out, 8'h3C);
        data_ready = 1'b0;
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        check("sim_w0_data", data_out, 8'h3C);
        send_bits(8'hF0, 7, 0);
        check("sim_pending", data_valid, 1);
        data_ready = 1'b1;
        send_bit(1'b0, 0);
        data_ready = 1'b0;
        check("sim_ready_data", data_out, 8'hF0);
        check("sim_ready_valid", data_valid, 1);
        check("sim_ready_overrun", overrun, 0);
        check("sim_ready_fe", frame_end, 1);

        // clr_overrun loses against a drop on the same edge
        send_byte(8'hA5, 0);
        send_bits(8'h3C, 7, 0);
        clr_overrun = 1'b1;
        send_bit(1'b0, 0);
        clr_overrun = 1'b0;
        check("sim_clr_overrun", overrun, 1);
        check("sim_clr_data", data_out, 8'hF0);
        send_byte(8'hF0, 0);
        check("sim_drop_fe", frame_end, 1);
        data_ready = 1'b1;
        clr_overrun = 1'b1;
        idle();
        clr_overrun = 1'b0;
        check("sim_final_valid", data_valid, 0);
        check("sim_final_overrun", overrun, 0);

        // Nominal frame with en alternating and s_in toggled on idle cycles
        send_bits(8'hA5, 7, 1);
        check("gap_lock_pre", sync_lock, 0);
        send_bit(1'b1, 1);
        check("gap_lock", sync_lock, 1);
        send_byte(8'h3C, 1);
        check("gap_w0_valid", data_valid, 1);
        check("gap_w0_data", data_out, 8'h3C);
        check("gap_w0_fe", frame_end, 0);
        send_byte(8'hF0, 1);
        check("gap_w1_valid", data_valid, 1);
        check("gap_w1_data", data_out, 8'hF0);
        check("gap_w1_fe", frame_end, 1);
        check("gap_unlock", sync_lock, 0);
        check("gap_overrun", overrun, 0);
        idle();
        check("gap_fe_pulse", frame_end, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
